imem_ctrl: RTL and testbench

//  Instruction-SRAM controller/arbiter sitting between the fetch stage and the instruction SRAM.

---
 rtl/imem_ctrl_pkg.sv | 26 ++
 rtl/imem_wait_counter.sv | 29 ++
 rtl/imem_ctrl.sv | 161 ++++++++++++++++
 tb/tb_imem_ctrl.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_ctrl_pkg.sv
// Shared definitions for the instruction-SRAM controller: FSM state encoding,
// wait-state limits and the wait counter width.
package imem_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_F_ACC = 2'd1,
        ST_L_ACC = 2'd2
    } imem_state_t;

    localparam int WAIT_STATES_MAX = 15;
    localparam int CNT_W           = 4;

    // Out-of-range wait-state settings clamp rather than wrap into a short access.
    function automatic logic [CNT_W-1:0] ws_to_cnt(input int ws);
        logic [CNT_W-1:0] r;
        if (ws > WAIT_STATES_MAX)
            r = CNT_W'(WAIT_STATES_MAX);
        else if (ws < 0)
            r = '0;
        else
            r = CNT_W'(ws);
        return r;
    endfunction

endpackage

// File: rtl/imem_wait_counter.sv
// Wait-state down-counter: loads at access start, decrements while an access is
// active and saturates at zero so a stray decrement can never wrap.
module imem_wait_counter
    import imem_ctrl_pkg::*;
#(
    parameter int W = CNT_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_dec,
    output logic         o_zero
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_cnt <= '0;
        else if (i_load)
            r_cnt <= i_load_val;
        else if (i_dec && (r_cnt != '0))
            r_cnt <= r_cnt - 1'b1;
    end

    assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/imem_ctrl.sv
// Instruction-SRAM controller: arbitrates the single SRAM port between fetch and
// the program loader. Optional one-entry fetch hit buffer under IMEM_HIT_BUF_EN.
module imem_ctrl
    import imem_ctrl_pkg::*;
#(
    parameter int PC_DATA_WIDTH     = 20,
    parameter int INSTRUCTION_WIDTH = 32,
    parameter int WAIT_STATES       = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         fetch_req_in,
    input  logic [PC_DATA_WIDTH-1:0]     fetch_addr_in,
    input  logic                         flush_in,
    output logic [INSTRUCTION_WIDTH-1:0] fetch_data_out,
    output logic                         fetch_ack_out,
    output logic                         fetch_stall_out,
    input  logic                         ldr_req_in,
    input  logic                         ldr_we_in,
    input  logic [PC_DATA_WIDTH-1:0]     ldr_addr_in,
    input  logic [INSTRUCTION_WIDTH-1:0] ldr_wdata_in,
    output logic [INSTRUCTION_WIDTH-1:0] ldr_rdata_out,
    output logic                         ldr_done_out,
    output logic [PC_DATA_WIDTH-1:0]     sram_addr_out,
    output logic [INSTRUCTION_WIDTH-1:0] sram_wdata_out,
    input  logic [INSTRUCTION_WIDTH-1:0] sram_rdata_in,
    output logic                         sram_ce_n_out,
    output logic                         sram_we_n_out
);

    localparam logic [CNT_W-1:0] LP_WS = ws_to_cnt(WAIT_STATES);

    imem_state_t                  r_state;
    imem_state_t                  w_state_nxt;
    logic [PC_DATA_WIDTH-1:0]     r_addr;
    logic [INSTRUCTION_WIDTH-1:0] r_wdata;
    logic                         r_we;
    logic [INSTRUCTION_WIDTH-1:0] r_ldr_rdata;

    logic                         w_cnt_zero;
    logic                         w_start_f;
    logic                         w_start_l;
    logic                         w_f_done;
    logic                         w_l_done;
    logic                         w_active;
    logic                         w_hit;
    logic [INSTRUCTION_WIDTH-1:0] w_hit_data;

    assign w_active = (r_state == ST_F_ACC) || (r_state == ST_L_ACC);

    imem_wait_counter #(
        .W (CNT_W)
    ) u_wait_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_start_f | w_start_l),
        .i_load_val (LP_WS),
        .i_dec      (w_active),
        .o_zero     (w_cnt_zero)
    );

    // Loader wins in IDLE; a flush only matters while a fetch read is in flight.
    always_comb begin
        w_state_nxt = r_state;
        w_start_f   = 1'b0;
        w_start_l   = 1'b0;
        w_f_done    = 1'b0;
        w_l_done    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (ldr_req_in) begin
                    w_state_nxt = ST_L_ACC;
                    w_start_l   = 1'b1;
                end else if (fetch_req_in && !w_hit) begin
                    w_state_nxt = ST_F_ACC;
                    w_start_f   = 1'b1;
                end
            end
            ST_F_ACC: begin
                if (flush_in) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_cnt_zero) begin
                    w_state_nxt = ST_IDLE;
                    w_f_done    = 1'b1;
                end
            end
            ST_L_ACC: begin
                if (w_cnt_zero) begin
                    w_state_nxt = ST_IDLE;
                    w_l_done    = 1'b1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_we        <= 1'b0;
            r_ldr_rdata <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_start_l) begin
                r_addr  <= ldr_addr_in;
                r_wdata <= ldr_wdata_in;
                r_we    <= ldr_we_in;
            end else if (w_start_f) begin
                r_addr <= fetch_addr_in;
                r_we   <= 1'b0;
            end
            if (w_l_done && !r_we)
                r_ldr_rdata <= sram_rdata_in;
        end
    end

`ifdef IMEM_HIT_BUF_EN
    logic                         r_buf_vld;
    logic [PC_DATA_WIDTH-1:0]     r_buf_addr;
    logic [INSTRUCTION_WIDTH-1:0] r_buf_data;

    // Any loader write to the buffered word makes the copy stale.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_buf_vld  <= 1'b0;
            r_buf_addr <= '0;
            r_buf_data <= '0;
        end else if (w_f_done) begin
            r_buf_vld  <= 1'b1;
            r_buf_addr <= r_addr;
            r_buf_data <= sram_rdata_in;
        end else if ((r_state == ST_L_ACC) && r_we && (r_addr == r_buf_addr)) begin
            r_buf_vld <= 1'b0;
        end
    end

    assign w_hit      = (r_state == ST_IDLE) && fetch_req_in && !ldr_req_in &&
                        r_buf_vld && (fetch_addr_in == r_buf_addr);
    assign w_hit_data = r_buf_data;
`else
    assign w_hit      = 1'b0;
    assign w_hit_data = '0;
`endif

    assign sram_ce_n_out   = !w_active;
    assign sram_we_n_out   = !((r_state == ST_L_ACC) && r_we);
    assign sram_addr_out   = r_addr;
    assign sram_wdata_out  = r_wdata;

    assign fetch_ack_out   = w_f_done | w_hit;
    assign fetch_data_out  = w_hit    ? w_hit_data    :
                             w_f_done ? sram_rdata_in : '0;
    assign fetch_stall_out = fetch_req_in & ~fetch_ack_out;

    // Read data passes straight through on the done cycle and is held afterwards.
    assign ldr_done_out    = w_l_done;
    assign ldr_rdata_out   = (w_l_done && !r_we) ? sram_rdata_in : r_ldr_rdata;

endmodule

// File: tb/tb_imem_ctrl.sv
// Self-checking bench for imem_ctrl with a behavioural SRAM and expected-data
// queues; exercises the hit buffer too when built with IMEM_HIT_BUF_EN.
module tb_imem_ctrl;

    localparam int PCW = 20;
    localparam int IW  = 32;
    localparam int WS  = 2;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           fetch_req_in;
    logic [PCW-1:0] fetch_addr_in;
    logic           flush_in;
    logic [IW-1:0]  fetch_data_out;
    logic           fetch_ack_out;
    logic           fetch_stall_out;
    logic           ldr_req_in;
    logic           ldr_we_in;
    logic [PCW-1:0] ldr_addr_in;
    logic [IW-1:0]  ldr_wdata_in;
    logic [IW-1:0]  ldr_rdata_out;
    logic           ldr_done_out;
    logic [PCW-1:0] sram_addr_out;
    logic [IW-1:0]  sram_wdata_out;
    logic [IW-1:0]  sram_rdata_in;
    logic           sram_ce_n_out;
    logic           sram_we_n_out;

    int checks   = 0;
    int failures = 0;

    logic [IW-1:0] f_q[$];
    logic [IW-1:0] l_q[$];

    bit [IW-1:0] wmem [0:1023];
    bit          wvld [0:1023];

    always #5 clk = ~clk;

    imem_ctrl #(
        .PC_DATA_WIDTH     (PCW),
        .INSTRUCTION_WIDTH (IW),
        .WAIT_STATES       (WS)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .fetch_req_in    (fetch_req_in),
        .fetch_addr_in   (fetch_addr_in),
        .flush_in        (flush_in),
        .fetch_data_out  (fetch_data_out),
        .fetch_ack_out   (fetch_ack_out),
        .fetch_stall_out (fetch_stall_out),
        .ldr_req_in      (ldr_req_in),
        .ldr_we_in       (ldr_we_in),
        .ldr_addr_in     (ldr_addr_in),
        .ldr_wdata_in    (ldr_wdata_in),
        .ldr_rdata_out   (ldr_rdata_out),
        .ldr_done_out    (ldr_done_out),
        .sram_addr_out   (sram_addr_out),
        .sram_wdata_out  (sram_wdata_out),
        .sram_rdata_in   (sram_rdata_in),
        .sram_ce_n_out   (sram_ce_n_out),
        .sram_we_n_out   (sram_we_n_out)
    );

    // Unwritten SRAM words read back as a tag of their own address.
    function automatic logic [IW-1:0] dflt(input logic [PCW-1:0] a);
        return 32'hC0DE_0000 | {12'h000, a};
    endfunction

    assign sram_rdata_in = sram_ce_n_out ? '0 :
                           (wvld[sram_addr_out[11:2]] ? wmem[sram_addr_out[11:2]] : dflt(sram_addr_out));

    always @(posedge clk) begin
        if (!sram_ce_n_out && !sram_we_n_out) begin
            wmem[sram_addr_out[11:2]] <= sram_wdata_out;
            wvld[sram_addr_out[11:2]] <= 1'b1;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; fetch_req_in = 1'b1; fetch_addr_in = 20'h100; flush_in = 1'b0;
        ldr_req_in = 1'b0; ldr_we_in = 1'b0; ldr_addr_in = '0; ldr_wdata_in = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (sram_ce_n_out !== 1'b1) begin failures++; $display("FAIL reset_ce_n got=%b exp=1", sram_ce_n_out); end
        checks++; if (sram_we_n_out !== 1'b1) begin failures++; $display("FAIL reset_we_n got=%b exp=1", sram_we_n_out); end
        checks++; if (fetch_ack_out !== 1'b0 || ldr_done_out !== 1'b0) begin failures++; $display("FAIL reset_ack_done got=%b%b exp=00", fetch_ack_out, ldr_done_out); end
        checks++; if (sram_addr_out !== '0 || sram_wdata_out !== '0) begin failures++; $display("FAIL reset_sram_bus got=%h/%h exp=0/0", sram_addr_out, sram_wdata_out); end
        checks++; if (fetch_data_out !== '0 || ldr_rdata_out !== '0) begin failures++; $display("FAIL reset_data got=%h/%h exp=0/0", fetch_data_out, ldr_rdata_out); end
        checks++; if (fetch_stall_out !== 1'b1) begin failures++; $display("FAIL reset_stall got=%b exp=1", fetch_stall_out); end
        fetch_req_in = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_fetch();
        int ce_cnt = 0;
        logic [IW-1:0] exp_v;
        f_q.delete();
        step();
        fetch_req_in = 1'b1; fetch_addr_in = 20'h100; f_q.push_back(32'hC0DE_0100);
        @(negedge clk);
        checks++; if (sram_ce_n_out !== 1'b1 || fetch_stall_out !== 1'b1) begin failures++; $display("FAIL fetch_req_cycle ce_n=%b stall=%b exp=1,1", sram_ce_n_out, fetch_stall_out); end
        for (int c = 1; c <= WS + 1; c++) begin
            step();
            if (c == 1) fetch_addr_in = 20'h104;
            @(negedge clk);
            if (!sram_ce_n_out) ce_cnt++;
            checks++; if (fetch_ack_out !== (c == WS + 1)) begin failures++; $display("FAIL fetch_ack_timing cyc=%0d got=%b exp=%b", c, fetch_ack_out, (c == WS + 1)); end
            checks++; if (fetch_stall_out !== (c != WS + 1)) begin failures++; $display("FAIL fetch_stall cyc=%0d got=%b exp=%b", c, fetch_stall_out, (c != WS + 1)); end
            if (fetch_ack_out) begin
                checks++;
                if (f_q.size() == 0) begin failures++; $display("FAIL fetch_data unexpected ack got=%h", fetch_data_out); end
                else begin
                    exp_v = f_q.pop_front();
                    if (fetch_data_out !== exp_v) begin failures++; $display("FAIL fetch_data got=%h exp=%h", fetch_data_out, exp_v); end
                end
                checks++; if (sram_addr_out !== 20'h100) begin failures++; $display("FAIL fetch_latched_addr got=%h exp=00100", sram_addr_out); end
            end
        end
        step();
        fetch_req_in = 1'b0;
        @(negedge clk);
        checks++; if (ce_cnt != WS + 1 || sram_ce_n_out !== 1'b1) begin failures++; $display("FAIL fetch_ce_cycles got=%0d/%b exp=%0d/1", ce_cnt, sram_ce_n_out, WS + 1); end
    endtask

    task automatic test_priority();
        int done_cyc = -1;
        int ack_cyc  = -1;
        int wen_cnt  = 0;
        logic [IW-1:0] exp_v;
        f_q.delete();
        step();
        fetch_req_in = 1'b1; fetch_addr_in = 20'h180;
        ldr_req_in = 1'b1; ldr_we_in = 1'b1; ldr_addr_in = 20'h200; ldr_wdata_in = 32'hDEADBEEF;
        f_q.push_back(32'hC0DE_0180);
        @(negedge clk);
        checks++; if (fetch_stall_out !== 1'b1) begin failures++; $display("FAIL prio_stall got=%b exp=1", fetch_stall_out); end
        for (int c = 1; c <= 4 * (WS + 1) + 4 && ack_cyc < 0; c++) begin
            step();
            if (done_cyc == c - 1) ldr_req_in = 1'b0;
            @(negedge clk);
            if (!sram_we_n_out) wen_cnt++;
            if (ldr_done_out) done_cyc = c;
            if (c == WS + 2) begin
                checks++; if (sram_ce_n_out !== 1'b1) begin failures++; $display("FAIL prio_idle_gap ce_n=%b exp=1", sram_ce_n_out); end
            end
            if (fetch_ack_out) begin
                ack_cyc = c;
                checks++;
                if (f_q.size() == 0) begin failures++; $display("FAIL prio_fetch_data unexpected ack got=%h", fetch_data_out); end
                else begin
                    exp_v = f_q.pop_front();
                    if (fetch_data_out !== exp_v) begin failures++; $display("FAIL prio_fetch_data got=%h exp=%h", fetch_data_out, exp_v); end
                end
            end
        end
        step();
        fetch_req_in = 1'b0;
        checks++; if (done_cyc != WS + 1) begin failures++; $display("FAIL prio_ldr_done_cycle got=%0d exp=%0d", done_cyc, WS + 1); end
        checks++; if (ack_cyc != 2 * WS + 3) begin failures++; $display("FAIL prio_fetch_ack_cycle got=%0d exp=%0d", ack_cyc, 2 * WS + 3); end
        checks++; if (wen_cnt != WS + 1) begin failures++; $display("FAIL prio_we_n_cycles got=%0d exp=%0d", wen_cnt, WS + 1); end
    endtask

    task automatic test_ldr_read();
        int done_cyc = -1;
        int wen_cnt  = 0;
        logic [IW-1:0] exp_v;
        l_q.delete();
        step();
        ldr_req_in = 1'b1; ldr_we_in = 1'b0; ldr_addr_in = 20'h200; ldr_wdata_in = '0;
        l_q.push_back(32'hDEADBEEF);
        for (int c = 1; c <= WS + 4 && done_cyc < 0; c++) begin
            step();
            @(negedge clk);
            if (!sram_we_n_out) wen_cnt++;
            if (ldr_done_out) begin
                done_cyc = c;
                checks++;
                if (l_q.size() == 0) begin failures++; $display("FAIL ldr_rdata unexpected done got=%h", ldr_rdata_out); end
                else begin
                    exp_v = l_q.pop_front();
                    if (ldr_rdata_out !== exp_v) begin failures++; $display("FAIL ldr_rdata got=%h exp=%h", ldr_rdata_out, exp_v); end
                end
            end
        end
        step();
        ldr_req_in = 1'b0;
        @(negedge clk);
        checks++; if (ldr_done_out !== 1'b0 || ldr_rdata_out !== 32'hDEADBEEF) begin failures++; $display("FAIL ldr_done_pulse_hold done=%b rdata=%h exp=0/deadbeef", ldr_done_out, ldr_rdata_out); end
        checks++; if (done_cyc != WS + 1) begin failures++; $display("FAIL ldr_read_latency got=%0d exp=%0d", done_cyc, WS + 1); end
        checks++; if (wen_cnt != 0) begin failures++; $display("FAIL ldr_read_we_n got=%0d exp=0", wen_cnt); end
    endtask

    task automatic test_flush();
        int ack_cyc = -1;
        logic [IW-1:0] exp_v;
        f_q.delete();
        step();
        fetch_req_in = 1'b1; fetch_addr_in = 20'h100;
        @(negedge clk);
        step();
        @(negedge clk);
        checks++; if (sram_ce_n_out !== 1'b0) begin failures++; $display("FAIL flush_acc_start ce_n=%b exp=0", sram_ce_n_out); end
        step();
        flush_in = 1'b1; fetch_addr_in = 20'h300;
        @(negedge clk);
        checks++; if (fetch_ack_out !== 1'b0) begin failures++; $display("FAIL flush_no_ack got=%b exp=0", fetch_ack_out); end
        step();
        flush_in = 1'b0; f_q.push_back(32'hC0DE_0300);
        @(negedge clk);
        checks++; if (sram_ce_n_out !== 1'b1 || fetch_ack_out !== 1'b0) begin failures++; $display("FAIL flush_idle ce_n=%b ack=%b exp=1,0", sram_ce_n_out, fetch_ack_out); end
        step();
        @(negedge clk);
        checks++; if (sram_ce_n_out !== 1'b0 || sram_addr_out !== 20'h300) begin failures++; $display("FAIL flush_refetch_start ce_n=%b addr=%h exp=0/00300", sram_ce_n_out, sram_addr_out); end
        for (int c = 5; c <= 12 && ack_cyc < 0; c++) begin
            step();
            @(negedge clk);
            if (fetch_ack_out) begin
                ack_cyc = c;
                checks++;
                if (f_q.size() == 0) begin failures++; $display("FAIL flush_refetch_data unexpected ack got=%h", fetch_data_out); end
                else begin
                    exp_v = f_q.pop_front();
                    if (fetch_data_out !== exp_v) begin failures++; $display("FAIL flush_refetch_data got=%h exp=%h", fetch_data_out, exp_v); end
                end
            end
        end
        step();
        fetch_req_in = 1'b0;
        checks++; if (ack_cyc != WS + 4) begin failures++; $display("FAIL flush_refetch_ack_cycle got=%0d exp=%0d", ack_cyc, WS + 4); end
    endtask

    task automatic test_async_reset();
        int ack_cyc = -1;
        logic [IW-1:0] exp_v;
        f_q.delete();
        step();
        fetch_req_in = 1'b1; fetch_addr_in = 20'h100;
        step();
        step();
        #2;
        checks++; if (sram_ce_n_out !== 1'b0) begin failures++; $display("FAIL arst_pre_active ce_n=%b exp=0", sram_ce_n_out); end
        rst_n = 1'b0;
        #1;
        checks++; if (sram_ce_n_out !== 1'b1 || fetch_ack_out !== 1'b0 || sram_addr_out !== '0) begin failures++; $display("FAIL arst_abort ce_n=%b ack=%b addr=%h exp=1,0,0", sram_ce_n_out, fetch_ack_out, sram_addr_out); end
        @(negedge clk);
        checks++; if (sram_ce_n_out !== 1'b1 || sram_we_n_out !== 1'b1) begin failures++; $display("FAIL arst_hold ce_n=%b we_n=%b exp=1,1", sram_ce_n_out, sram_we_n_out); end
        step();
        rst_n = 1'b1; f_q.push_back(32'hC0DE_0100);
        for (int c = 1; c <= WS + 4 && ack_cyc < 0; c++) begin
            step();
            @(negedge clk);
            if (fetch_ack_out) begin
                ack_cyc = c;
                checks++;
                if (f_q.size() == 0) begin failures++; $display("FAIL arst_refetch_data unexpected ack got=%h", fetch_data_out); end
                else begin
                    exp_v = f_q.pop_front();
                    if (fetch_data_out !== exp_v) begin failures++; $display("FAIL arst_refetch_data got=%h exp=%h", fetch_data_out, exp_v); end
                end
            end
        end
        step();
        fetch_req_in = 1'b0;
        checks++; if (ack_cyc != WS + 1) begin failures++; $display("FAIL arst_refetch_latency got=%0d exp=%0d", ack_cyc, WS + 1); end
    endtask

`ifdef IMEM_HIT_BUF_EN
    task automatic test_hit_buf();
        int done_cyc = -1;
        int ack_cyc  = -1;
        logic [IW-1:0] exp_v;
        f_q.delete();
        step();
        fetch_req_in = 1'b1; fetch_addr_in = 20'h100; f_q.push_back(32'hC0DE_0100);
        @(negedge clk);
        checks++; if (fetch_ack_out !== 1'b1 || sram_ce_n_out !== 1'b1) begin failures++; $display("FAIL hit_ack ack=%b ce_n=%b exp=1,1", fetch_ack_out, sram_ce_n_out); end
        if (fetch_ack_out && f_q.size() != 0) begin
            exp_v = f_q.pop_front();
            checks++; if (fetch_data_out !== exp_v) begin failures++; $display("FAIL hit_data got=%h exp=%h", fetch_data_out, exp_v); end
        end
        step();
        fetch_req_in = 1'b0;
        ldr_req_in = 1'b1; ldr_we_in = 1'b1; ldr_addr_in = 20'h100; ldr_wdata_in = 32'h1234_5678;
        for (int c = 1; c <= WS + 4 && done_cyc < 0; c++) begin
            step();
            @(negedge clk);
            if (ldr_done_out) done_cyc = c;
        end
        step();
        ldr_req_in = 1'b0;
        checks++; if (done_cyc != WS + 1) begin failures++; $display("FAIL hit_ldr_write_done got=%0d exp=%0d", done_cyc, WS + 1); end
        step();
        fetch_req_in = 1'b1; fetch_addr_in = 20'h100;
        f_q.delete(); f_q.push_back(32'h1234_5678);
        @(negedge clk);
        checks++; if (fetch_ack_out !== 1'b0) begin failures++; $display("FAIL hit_invalidated ack=%b exp=0", fetch_ack_out); end
        for (int c = 1; c <= WS + 4 && ack_cyc < 0; c++) begin
            step();
            @(negedge clk);
            if (fetch_ack_out) begin
                ack_cyc = c;
                exp_v = f_q.pop_front();
                checks++; if (fetch_data_out !== exp_v) begin failures++; $display("FAIL hit_miss_data got=%h exp=%h", fetch_data_out, exp_v); end
            end
        end
        step();
        fetch_req_in = 1'b0;
        checks++; if (ack_cyc != WS + 1) begin failures++; $display("FAIL hit_miss_latency got=%0d exp=%0d", ack_cyc, WS + 1); end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_fetch();
        test_priority();
        test_ldr_read();
        test_flush();
        test_async_reset();
`ifdef IMEM_HIT_BUF_EN
        test_hit_buf();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
